conv5k_sequencer: RTL

- Controller that sequences the 5x5-kernel PE array (five 1-D 5-tap PE rows plus output adder tree) over one image strip.
- Loads the 25 kernel weights serially into a weight bank and accepts 5-pixel columns from an upstream stream.
- Drives the array's row inputs and 3-bit phase select, and captures the five 16-bit array results with a valid strobe after the array latency.
- Sits between the line-buffer/DMA front end and the PE array.

---
 rtl/conv5k_pkg.sv | 20 ++
 rtl/conv5k_valid_pipe.sv | 28 ++
 rtl/conv5k_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv5k_pkg.sv
// Shared types and constants for the 5x5 convolution sequencer.
package conv5k_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int KTAPS    = 5;
  localparam int NWEIGHTS = 25;
  localparam int DATA_W   = 8;
  localparam int RES_W    = 16;

  localparam logic [2:0] SEL_LAST = 3'd4;

endpackage

// File: rtl/conv5k_valid_pipe.sv
// Result-token delay line matching the PE array latency; empty flag lets the controller drain.
module conv5k_valid_pipe #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic pop,
  output logic empty
);

  logic [STAGES-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign pop   = vld_p[STAGES-1];
  assign empty = (vld_p == '0);

endmodule

// File: rtl/conv5k_sequencer.sv
// Sequences the 5x5 PE array over one strip: weight load, column fetch, 5-phase run, result capture.
// Defining CONV5K_STALL_CNT_EN adds the stall_cnt upstream-starvation counter output.
module conv5k_sequencer
  import conv5k_pkg::*;
#(
  parameter int NUM_COLS = 32,
  parameter int PE_LAT   = 2,
  parameter int CW       = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         wt_valid,
  input  logic [DATA_W-1:0]            wt_data,
  output logic                         wt_ready,
  output logic [NWEIGHTS*DATA_W-1:0]   w_flat,
  input  logic                         pix_valid,
  input  logic [KTAPS*DATA_W-1:0]      pix_data,
  output logic                         pix_ready,
  output logic [KTAPS*DATA_W-1:0]      pe_row,
  output logic [2:0]                   pe_sel,
  input  logic [KTAPS*RES_W-1:0]       pe_y,
  output logic                         out_valid,
  output logic [KTAPS*RES_W-1:0]       out_y
`ifdef CONV5K_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam logic [CW:0] NCOLS = (CW+1)'(NUM_COLS);
  localparam logic [4:0]  WLAST = 5'(NWEIGHTS - 1);

  logic        rst;
  state_t      state, state_nx;
  logic [4:0]  wcnt;
  logic [CW-1:0] ccnt;
  logic [CW:0] ccnt_inc;
  logic        more_cols;
  logic        take_col;
  logic        push;
  logic        pop;
  logic        empty;

  // The reset pin is active-high despite its name.
  assign rst       = reset_n;
  assign ccnt_inc  = {1'b0, ccnt} + 1'b1;
  assign more_cols = (ccnt_inc < NCOLS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      ccnt   <= '0;
      pe_sel <= 3'd0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        wcnt <= '0;
        ccnt <= '0;
      end
      if (wt_ready && wt_valid) wcnt <= wcnt + 5'd1;
      if (push) ccnt <= ccnt + 1'b1;
      pe_sel <= (state == S_RUN && pe_sel != SEL_LAST) ? pe_sel + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    wt_ready  = 1'b0;
    pix_ready = 1'b0;
    take_col  = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        wt_ready = 1'b1;
        if (wt_valid && wcnt == WLAST) state_nx = S_FETCH;
      end
      S_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          take_col = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        // Last phase of a column: retire it and, if upstream is ready, chain the next one.
        if (pe_sel == SEL_LAST) begin
          push      = 1'b1;
          pix_ready = more_cols;
          if (!more_cols) begin
            state_nx = S_DRAIN;
          end else if (pix_valid) begin
            take_col = 1'b1;
          end else begin
            state_nx = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (empty) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_flat    <= '0;
      pe_row    <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wt_ready && wt_valid) w_flat[int'(wcnt)*DATA_W +: DATA_W] <= wt_data;
      if (take_col) pe_row <= pix_data;
      out_valid <= pop;
      if (pop) out_y <= pe_y;
    end
  end

  conv5k_valid_pipe #(
    .STAGES(PE_LAT)
  ) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .empty(empty)
  );

`ifdef CONV5K_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Waiting in FETCH once the strip has started streaming means upstream starved us.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      stall_cnt <= '0;
    end else if (state == S_FETCH && ccnt != '0) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
